// File: rtl/free_list_multi.sv
// free_list_multi: multi-lane physical-register free list (circular FIFO of PR tags).
// Define FREE_LIST_CHECK_EN to track list membership and reject duplicate frees.
module free_list_multi #(
    parameter int PR_W    = 6,
    parameter int NUM_PR  = 64,
    parameter int NUM_AR  = 32,
    parameter int ALLOC_W = 2,
    parameter int FREE_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ALLOC_W-1:0]       alloc_req,
    input  logic                     hazard_stall,
    input  logic                     recover,
    input  logic [FREE_W-1:0]        retire_vld,
    input  logic [FREE_W*PR_W-1:0]   retire_pr,
    input  logic [FREE_W-1:0]        flush_vld,
    input  logic [FREE_W*PR_W-1:0]   flush_pr,
    output logic [ALLOC_W*PR_W-1:0]  alloc_pr,
    output logic                     alloc_ok,
    output logic                     empty,
    output logic [PR_W:0]            free_cnt,
    output logic                     err
);
    localparam int DEPTH  = NUM_PR - NUM_AR;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CW     = PR_W + 1;
    localparam int PUSH_W = 2 * FREE_W;
    localparam logic [PTR_W:0] DEPTH_P = (PTR_W+1)'(DEPTH);

    logic [PR_W-1:0]        entries [DEPTH];
    logic [PTR_W-1:0]       head, tail;
    logic [CW-1:0]          count, n_alloc, n_grant, n_push, space;
    logic [PUSH_W-1:0]      push_vld, wr_en;
    logic [PUSH_W*PR_W-1:0] push_pr;
    logic [PTR_W-1:0]       wr_idx [PUSH_W];
    logic                   ovf, dup;
`ifdef FREE_LIST_CHECK_EN
    logic [NUM_PR-1:0]      in_list, in_list_nxt, seen;
`endif

    function automatic logic [PTR_W-1:0] wrap(input logic [PTR_W:0] x);
        return PTR_W'(x >= DEPTH_P ? x - DEPTH_P : x);
    endfunction

    // Retire lanes precede flush lanes; compaction below keeps that order.
    assign push_vld = {flush_vld, retire_vld & {FREE_W{!hazard_stall}}};
    assign push_pr  = {flush_pr, retire_pr};
    assign free_cnt = count;
    assign empty    = count == '0;

    always_comb begin
        n_alloc  = '0;
        alloc_pr = '0;
        for (int i = 0; i < ALLOC_W; i++) begin
            if (alloc_req[i])
                alloc_pr[i*PR_W +: PR_W] = entries[wrap({1'b0, head} + (PTR_W+1)'(n_alloc))];
            n_alloc = n_alloc + CW'(alloc_req[i]);
        end
        alloc_ok = count >= n_alloc && !recover && !hazard_stall;
        n_grant  = alloc_ok ? n_alloc : '0;
    end

    // Space accounts for this cycle's pops; freed tags never bypass to alloc_pr.
    always_comb begin
        space  = CW'(DEPTH) - count + n_grant;
        n_push = '0;
        ovf    = 1'b0;
        dup    = 1'b0;
        wr_en  = '0;
`ifdef FREE_LIST_CHECK_EN
        seen   = '0;
`endif
        for (int k = 0; k < PUSH_W; k++) begin
            wr_idx[k] = wrap({1'b0, tail} + (PTR_W+1)'(n_push));
            if (push_vld[k]) begin
`ifdef FREE_LIST_CHECK_EN
                if (in_list[push_pr[k*PR_W +: PR_W]] || seen[push_pr[k*PR_W +: PR_W]])
                    dup = 1'b1;
                else if (n_push >= space)
                    ovf = 1'b1;
                else begin
                    wr_en[k] = 1'b1;
                    n_push   = n_push + 1'b1;
                    seen[push_pr[k*PR_W +: PR_W]] = 1'b1;
                end
`else
                if (n_push >= space)
                    ovf = 1'b1;
                else begin
                    wr_en[k] = 1'b1;
                    n_push   = n_push + 1'b1;
                end
`endif
            end
        end
    end

`ifdef FREE_LIST_CHECK_EN
    always_comb begin
        in_list_nxt = in_list;
        for (int i = 0; i < ALLOC_W; i++)
            if (alloc_req[i] && alloc_ok) in_list_nxt[alloc_pr[i*PR_W +: PR_W]] = 1'b0;
        for (int k = 0; k < PUSH_W; k++)
            if (wr_en[k]) in_list_nxt[push_pr[k*PR_W +: PR_W]] = 1'b1;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= CW'(DEPTH);
            err   <= 1'b0;
            for (int k = 0; k < DEPTH; k++) entries[k] <= PR_W'(NUM_AR + k);
`ifdef FREE_LIST_CHECK_EN
            in_list <= {{DEPTH{1'b1}}, {NUM_AR{1'b0}}};
`endif
        end else begin
            head  <= wrap({1'b0, head} + (PTR_W+1)'(n_grant));
            tail  <= wrap({1'b0, tail} + (PTR_W+1)'(n_push));
            count <= count - n_grant + n_push;
            err   <= err | ovf | dup;
            for (int k = 0; k < PUSH_W; k++)
                if (wr_en[k]) entries[wr_idx[k]] <= push_pr[k*PR_W +: PR_W];
`ifdef FREE_LIST_CHECK_EN
            in_list <= in_list_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_free_list_multi.sv
// tb_free_list_multi: scoreboard bench for free_list_multi against a queue model of the list.
module tb_free_list_multi;
    localparam int DEPTH = 32;

    typedef struct {
        int ok;
        int cnt;
        int err;
        int pr0;
        int pr1;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  alloc_req = '0;
    logic        hazard_stall = 1'b0;
    logic        recover = 1'b0;
    logic [1:0]  retire_vld = '0;
    logic [11:0] retire_pr = '0;
    logic [1:0]  flush_vld = '0;
    logic [11:0] flush_pr = '0;
    logic [11:0] alloc_pr;
    logic        alloc_ok;
    logic        empty;
    logic [6:0]  free_cnt;
    logic        err;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   fl[$];
    bit   m_err;
    exp_t sb[$];

    always #5 clk = ~clk;

    free_list_multi dut (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .hazard_stall(hazard_stall),
        .recover(recover), .retire_vld(retire_vld), .retire_pr(retire_pr),
        .flush_vld(flush_vld), .flush_pr(flush_pr), .alloc_pr(alloc_pr),
        .alloc_ok(alloc_ok), .empty(empty), .free_cnt(free_cnt), .err(err)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_push(input int t);
        if (fl.size() < DEPTH) fl.push_back(t);
        else m_err = 1'b1;
    endtask

    // Reset is asserted while requests and frees are active; they must be discarded.
    task automatic do_reset();
        @(negedge clk);
        alloc_req  = 2'b11;
        flush_vld  = 2'b11;
        flush_pr   = {6'd1, 6'd2};
        rst        = 1'b1;
        @(negedge clk);
        alloc_req  = '0;
        flush_vld  = '0;
        rst        = 1'b0;
        fl.delete();
        for (int k = 0; k < DEPTH; k++) fl.push_back(32 + k);
        m_err = 1'b0;
    endtask

    task automatic step(input logic [1:0] req, input logic hs, input logic rec,
                        input logic [1:0] rv, input int r0, input int r1,
                        input logic [1:0] fv, input int f0, input int f1);
        exp_t e;
        int   n, j;
        @(negedge clk);
        alloc_req    = req;
        hazard_stall = hs;
        recover      = rec;
        retire_vld   = rv;
        retire_pr    = {6'(r1), 6'(r0)};
        flush_vld    = fv;
        flush_pr     = {6'(f1), 6'(f0)};
        n     = int'(req[0]) + int'(req[1]);
        e.ok  = (fl.size() >= n && !rec && !hs) ? 1 : 0;
        e.cnt = fl.size();
        e.err = int'(m_err);
        j = 0;
        e.pr0 = 0;
        e.pr1 = 0;
        if (req[0]) begin e.pr0 = j < fl.size() ? fl[j] : -1; j++; end
        if (req[1]) e.pr1 = j < fl.size() ? fl[j] : -1;
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        chk("alloc_ok", int'(alloc_ok), e.ok);
        chk("free_cnt", int'(free_cnt), e.cnt);
        chk("empty", int'(empty), e.cnt == 0 ? 1 : 0);
        chk("err", int'(err), e.err);
        if (e.pr0 >= 0) chk("alloc_pr0", int'(alloc_pr[5:0]), e.pr0);
        if (e.pr1 >= 0) chk("alloc_pr1", int'(alloc_pr[11:6]), e.pr1);
        if (e.ok == 1) repeat (n) void'(fl.pop_front());
        if (!hs && rv[0]) model_push(r0);
        if (!hs && rv[1]) model_push(r1);
        if (fv[0]) model_push(f0);
        if (fv[1]) model_push(f1);
    endtask

    initial begin
        do_reset();
        // drain the list two at a time from reset
        repeat (16) step(2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        step(2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        // free while empty: not allocatable until next cycle
        step(2'b01, 0, 0, 2'b01, 12, 0, 2'b00, 0, 0);
        step(2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        // count=1: pair request refused, single granted
        step(2'b00, 0, 0, 2'b01, 20, 0, 2'b00, 0, 0);
        step(2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        step(2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        step(2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        // stall gates alloc and retire, not flush
        step(2'b11, 1, 0, 2'b01, 7, 0, 2'b01, 9, 0);
        step(2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        step(2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        // recovery pushes squashed tags, blocks alloc
        step(2'b11, 0, 1, 2'b00, 0, 0, 2'b11, 4, 5);
        step(2'b11, 0, 1, 2'b00, 0, 0, 2'b01, 10, 0);
        step(2'b11, 0, 1, 2'b00, 0, 0, 2'b00, 0, 0);
        step(2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        step(2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        step(2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        // lane compaction and four pushes with two pops in one cycle
        do_reset();
        step(2'b10, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        step(2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        step(2'b11, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        step(2'b11, 0, 0, 2'b11, 1, 2, 2'b11, 3, 6);
        step(2'b11, 1, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        step(2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        // free into a full list: dropped, err raised and sticky
        do_reset();
        step(2'b00, 0, 0, 2'b01, 40, 0, 2'b00, 0, 0);
        step(2'b01, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        step(2'b00, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
